// File: rtl/vga_defs_pkg.sv
// Shared VGA display definitions: resolution select, frame geometry and pixel format.
package vga_defs;

  typedef enum logic [0:0] {RES_640X480, RES_800X600} vgaRes_t;

  localparam vgaRes_t RESOLUTION = RES_640X480;
  localparam int PIXEL_SIZE = 8;
  localparam int WIDTH  = (RESOLUTION == RES_800X600) ? 800 : 640;
  localparam int HEIGHT = (RESOLUTION == RES_800X600) ? 600 : 480;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel prefetch FIFO with occupancy count and single-cycle flush.
module vga_pix_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      pushData,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic              doPush, doPop;

  assign empty  = (count == '0);
  assign head   = mem[rdPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && ((count != (PTR_W+1)'(DEPTH)) || doPop);

  // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, doPush} - {{PTR_W{1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: prefetches pixels from cellular RAM over a req/ack port
// and presents one pixel per display-enable cycle, with optional 2x doubling.
module vga_fb_scanout
  import vga_defs::*;
#(
  parameter int H_ACTIVE   = WIDTH,
  parameter int V_ACTIVE   = HEIGHT,
  parameter int PIXEL_W    = PIXEL_SIZE,
  parameter int ADDR_W     = 26,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic               de,
  input  logic [ADDR_W-1:0]  fb_base,
  input  logic               double_en,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic               mem_rvalid,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic [PIXEL_W-1:0] pixel,
  output logic               underflow
);

  localparam int X_W   = ctrWidth(H_ACTIVE);
  localparam int Y_W   = ctrWidth(V_ACTIVE);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state, stateNext;
  logic               doubleMode, dropPending, secondPass, showPhase;
  logic [ADDR_W-1:0]  curAddr, lineStart;
  logic [X_W-1:0]     xCnt;
  logic [Y_W-1:0]     yCnt;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoEmpty;
  logic [PIXEL_W-1:0] fifoHead;
  logic               lineEnd, lastFetch, fetchDone, accepted, outstanding, creditOk;
  logic               fifoPop;

  assign mem_addr    = curAddr;
  assign accepted    = mem_req && mem_ack;
  assign fetchDone   = (state == S_WAIT) && mem_rvalid;
  assign outstanding = dropPending || (state == S_WAIT);
  assign creditOk    = (int'(fifoCount) + int'(outstanding)) < FIFO_DEPTH;

  assign lineEnd   = doubleMode ? (xCnt == X_W'(H_ACTIVE/2 - 1)) : (xCnt == X_W'(H_ACTIVE - 1));
  assign lastFetch = lineEnd && (doubleMode ? (secondPass && (yCnt == Y_W'(V_ACTIVE/2 - 1)))
                                            : (yCnt == Y_W'(V_ACTIVE - 1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    stateNext = state;
    mem_req   = 1'b0;
    case (state)
      S_IDLE: ;
      S_REQ: begin
        mem_req = !dropPending && creditOk;
        if (mem_req && mem_ack) stateNext = S_WAIT;
      end
      S_WAIT:  if (mem_rvalid) stateNext = lastFetch ? S_DONE : S_REQ;
      S_DONE: ;
      default: stateNext = S_IDLE;
    endcase
    if (frame_start) stateNext = S_REQ;
  end

  // A read already accepted when a new frame begins must drain before the next request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          dropPending <= 1'b0;
    else if (frame_start) dropPending <= accepted || ((dropPending || state == S_WAIT) && !mem_rvalid);
    else if (mem_rvalid)  dropPending <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      doubleMode <= 1'b0;
      curAddr    <= '0;
      lineStart  <= '0;
      xCnt       <= '0;
      yCnt       <= '0;
      secondPass <= 1'b0;
    end else if (frame_start) begin
      doubleMode <= double_en;
      curAddr    <= fb_base;
      lineStart  <= fb_base;
      xCnt       <= '0;
      yCnt       <= '0;
      secondPass <= 1'b0;
    end else if (fetchDone && !lastFetch) begin
      if (!lineEnd) begin
        xCnt    <= xCnt + 1'b1;
        curAddr <= curAddr + 1'b1;
      end else begin
        xCnt <= '0;
        if (doubleMode && !secondPass) begin
          secondPass <= 1'b1;
          curAddr    <= lineStart;
        end else begin
          secondPass <= 1'b0;
          yCnt       <= yCnt + 1'b1;
          curAddr    <= curAddr + 1'b1;
          lineStart  <= curAddr + 1'b1;
        end
      end
    end
  end

  // In doubled mode the head is shown twice and only popped on its second showing.
  assign fifoPop = de && !fifoEmpty && (!doubleMode || showPhase);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel     <= '0;
      underflow <= 1'b0;
      showPhase <= 1'b0;
    end else begin
      pixel <= (de && !fifoEmpty) ? fifoHead : '0;
      if (de && fifoEmpty) underflow <= 1'b1;
      if (frame_start)                          showPhase <= 1'b0;
      else if (de && !fifoEmpty && doubleMode)  showPhase <= !showPhase;
    end
  end

  vga_pix_fifo #(
    .DATA_W (PIXEL_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (frame_start),
    .push     (fetchDone && !frame_start),
    .pushData (mem_rdata),
    .pop      (fifoPop),
    .head     (fifoHead),
    .count    (fifoCount),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout: random-latency memory model, reference pixel
// stream computed from frame geometry, and a decoupled output monitor.
module tb_vga_fb_scanout;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 26;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_start = 1'b0;
  logic          de = 1'b0;
  logic [AW-1:0] fb_base = '0;
  logic          double_en = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [PW-1:0] mem_rdata = '0;
  logic [PW-1:0] pixel;
  logic          underflow;

  int nChecks = 0;
  int nFails  = 0;

  int ackMin = 0, ackMax = 3, rvMin = 0, rvMax = 3;
  int frameId = 0, reqCount = 0, pushCount = 0, popCount = 0, deCount = 0;
  logic [AW-1:0] firstAddr = '0;
  logic          curDouble = 1'b0;
  logic          monOn = 1'b0;
  logic [PW-1:0] expQ[$];

  int            mdlDelay, mdlFrame;
  logic [AW-1:0] mdlAddr;
  logic [PW-1:0] monExp;

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .PIXEL_W    (PW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_start (frame_start),
    .de          (de),
    .fb_base     (fb_base),
    .double_en   (double_en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .pixel       (pixel),
    .underflow   (underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data word is the low byte of its address; one read serviced at a time.
  always begin : mem_model
    @(negedge clk);
    if (resetn && mem_req) begin
      mdlDelay = $urandom_range(ackMax, ackMin);
      repeat (mdlDelay) @(negedge clk);
      if (resetn && mem_req) begin
        mdlFrame = frameId;
        mdlAddr  = mem_addr;
        if (reqCount == 0) firstAddr = mdlAddr;
        reqCount++;
        check("credit_fifo_room", 64'((pushCount - popCount) < DEPTH), 64'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mdlDelay = $urandom_range(rvMax, rvMin);
        repeat (mdlDelay) begin
          check("single_outstanding", mem_req, 0);
          @(negedge clk);
        end
        check("single_outstanding", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = mdlAddr[7:0];
        if (mdlFrame == frameId) pushCount++;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  always begin : monitor
    @(posedge clk);
    #1;
    if (monOn) begin
      if (de) begin
        check("pixel_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          monExp = expQ.pop_front();
          check("pixel", pixel, monExp);
        end
        deCount++;
        if (!curDouble || (deCount % 2 == 0)) popCount++;
      end else begin
        check("blank_pixel", pixel, 0);
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] base, input logic dbl);
    logic [AW-1:0] a;
    int off;
    @(negedge clk);
    fb_base     = base;
    double_en   = dbl;
    frame_start = 1'b1;
    frameId++;
    reqCount  = 0;
    pushCount = 0;
    popCount  = 0;
    deCount   = 0;
    curDouble = dbl;
    expQ.delete();
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        off = dbl ? (r / 2) * (H / 2) + c / 2 : r * H + c;
        a = base + AW'(off);
        expQ.push_back(a[7:0]);
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic play_frame(input logic dbl);
    repeat (40) @(negedge clk);
    for (int i = 0; i < H * V; i++) begin
      de = 1'b1;
      @(negedge clk);
      de = 1'b0;
      repeat ($urandom_range(12, 9)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("requests_per_frame", reqCount, dbl ? H * V / 2 : H * V);
    check("all_pixels_shown", expQ.size(), 0);
    check("no_underflow", underflow, 0);
    check("idle_after_frame", mem_req, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit got;

    repeat (3) @(negedge clk);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_pixel", pixel, 0);
    check("reset_underflow", underflow, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_req", mem_req, 0);

    monOn = 1'b1;
    start_frame(AW'(32'h100), 1'b0);
    play_frame(1'b0);
    check("first_addr_normal", firstAddr, AW'(32'h100));

    start_frame('0, 1'b1);
    play_frame(1'b1);

    for (int f = 0; f < 2; f++) begin
      got = 1'(f);
      start_frame(AW'($urandom), got);
      play_frame(got);
    end

    start_frame(AW'(32'h3FF_FFF8), 1'b1);
    play_frame(1'b1);

    // Frame restart while a read is in flight: its data must be discarded.
    ackMin = 0; ackMax = 0; rvMin = 3; rvMax = 3;
    start_frame(AW'(32'h2055), 1'b0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      if (mem_ack) got = 1'b1;
    end
    check("restart_ack_seen", got, 1);
    start_frame(AW'(32'h3000), 1'b0);
    check("restart_req_held", mem_req, 0);
    ackMin = 0; ackMax = 3; rvMin = 0; rvMax = 3;
    play_frame(1'b0);
    check("restart_first_addr", firstAddr, AW'(32'h3000));

    // Starved scanout: memory stalls, display keeps running.
    monOn = 1'b0;
    ackMin = 40; ackMax = 40;
    start_frame(AW'(32'h500), 1'b0);
    for (int i = 0; i < 6; i++) begin
      de = 1'b1;
      @(posedge clk);
      #1;
      check("starved_pixel", pixel, 0);
      check("underflow_set", underflow, 1);
      @(negedge clk);
    end
    de = 1'b0;
    repeat (60) @(negedge clk);
    check("underflow_sticky", underflow, 1);

    // Reset mid-frame while a request is pending.
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1'b1;
    end
    check("req_pending_before_reset", got, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_mem_req", mem_req, 0);
    check("midreset_pixel", pixel, 0);
    check("midreset_underflow", underflow, 0);
    check("midreset_mem_addr", mem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
